cache_sram_assoc: RTL and testbench

Parametrised N-way set-associative tag/data store for the L2 level. It is the successor of the fixed 2-way, 32-set L2 array. Lookup stays combinational. Replacement becomes true-LRU by per-way age counters over any power-of-two way count. New in this block: dirty-victim reporting, a multi-cycle flush walker, and an optional hit/miss statistics block. It sits between the L1 miss path and the memory controller; the L2 controller FSM drives all of its strobes.

---
 rtl/cache_sram_pkg.sv | 18 +
 rtl/cache_sram_assoc_lru.sv | 27 ++
 rtl/cache_sram_assoc.sv | 168 ++++++++++++++++
 tb/tb_cache_sram_assoc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sram_pkg.sv
// cache_sram_pkg: shared constants, entry layout and flush FSM states for cache_sram_assoc.
package cache_sram_pkg;
    localparam int WAYS_DEF   = 4;
    localparam int SETS_DEF   = 32;
    localparam int TAG_W_DEF  = 23;
    localparam int LINE_W_DEF = 128;

    // Entry layout at the default widths.
    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic                  i_d;
        logic [TAG_W_DEF-1:0]  tag;
        logic [LINE_W_DEF-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, FLUSH} flush_state_e;
endpackage

// File: rtl/cache_sram_assoc_lru.sv
// cache_lru_age: age vector of one set, true-LRU touch update and oldest-way select.
//   age_i       current ages (permutation of 0..WAYS-1)
//   touch_i     apply a touch to touch_way_i
//   touch_way_i way being made most recent
//   age_o       ages after the optional touch
//   oldest_o    way whose age is WAYS-1
module cache_lru_age #(
    parameter int WAYS = 4,
    parameter int AW   = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] age_i,
    input  logic                    touch_i,
    input  logic [AW-1:0]           touch_way_i,
    output logic [WAYS-1:0][AW-1:0] age_o,
    output logic [AW-1:0]           oldest_o
);
    always_comb begin
        oldest_o = '0;
        age_o    = age_i;
        for (int w = WAYS - 1; w >= 0; w--)
            if (age_i[w] == AW'(WAYS - 1)) oldest_o = AW'(w);
        for (int w = 0; w < WAYS; w++)
            age_o[w] = !touch_i ? age_i[w] :
                       (AW'(w) == touch_way_i) ? '0 :
                       (age_i[w] < age_i[touch_way_i]) ? age_i[w] + AW'(1) : age_i[w];
    end
endmodule

// File: rtl/cache_sram_assoc.sv
// cache_sram_assoc: N-way set-associative L2 tag/data store with true-LRU, dirty victim and flush walker.
//   clk, rst_n          clock, asynchronous active-low reset
//   addr_i, I_D         lookup address {tag, index} and instruction/data class
//   read_i, write_i     lookup touch strobe, fill/update strobe (dirty_i, wdata_i)
//   flush_i             starts a SETS-cycle invalidate walk
//   rdata_o, hit_o      selected way data, tag hit
//   victim_dirty_o/tag  selected way dirty state and tag for writeback
//   busy_o              flush walker active
//   hit_cnt_o/miss_cnt_o  read hit/miss counters, only with CACHE_SRAM_STATS_EN defined
module cache_sram_assoc
    import cache_sram_pkg::*;
#(
    parameter int WAYS   = WAYS_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_W+$clog2(SETS)-1:0] addr_i,
    input  logic                          I_D,
    input  logic                          read_i,
    input  logic                          write_i,
    input  logic                          dirty_i,
    input  logic [LINE_W-1:0]             wdata_i,
    input  logic                          flush_i,
    output logic [LINE_W-1:0]             rdata_o,
    output logic                          hit_o,
    output logic                          victim_dirty_o,
    output logic [TAG_W-1:0]              victim_tag_o,
`ifdef CACHE_SRAM_STATS_EN
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o,
`endif
    output logic                          busy_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AW    = $clog2(WAYS);

    flush_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                  cnt_q, cnt_d;
    logic [SETS-1:0][WAYS-1:0]         valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][AW-1:0] age_q, age_d;
    logic [TAG_W-1:0]                  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0]                 data_mem [SETS][WAYS];
    logic                              id_mem   [SETS][WAYS];

    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          tag;
    logic [WAYS-1:0]           hit;
    logic [AW-1:0]             sel, oldest;
    logic [WAYS-1:0][AW-1:0]   age_new;
    logic                      flushing, hit_any, we, touch;

    assign idx      = addr_i[IDX_W-1:0];
    assign tag      = addr_i[TAG_W+IDX_W-1:IDX_W];
    assign flushing = state_q == FLUSH;
    assign hit_any  = |hit;
    assign we       = write_i && !flushing;
    // A write already targets the hitting way when there is one, so one touch of sel covers read+write.
    assign touch    = we || (read_i && hit_any && !flushing);

    // Hit first, then a free way, then the LRU way.
    always_comb begin
        hit = '0;
        sel = oldest;
        for (int w = 0; w < WAYS; w++)
            hit[w] = valid_q[idx][w] && tag_mem[idx][w] == tag && id_mem[idx][w] == I_D;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx][w]) sel = AW'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (hit[w]) sel = AW'(w);
    end

    cache_lru_age #(.WAYS(WAYS), .AW(AW)) u_lru (
        .age_i      (age_q[idx]),
        .touch_i    (touch),
        .touch_way_i(sel),
        .age_o      (age_new),
        .oldest_o   (oldest)
    );

    assign rdata_o        = data_mem[idx][sel];
    assign victim_tag_o   = tag_mem[idx][sel];
    assign hit_o          = hit_any && !flushing;
    assign victim_dirty_o = valid_q[idx][sel] && dirty_q[idx][sel] && !flushing;
    assign busy_o         = flushing;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        age_d   = age_q;
        if (flushing) begin
            valid_d[cnt_q] = '0;
            dirty_d[cnt_q] = '0;
            for (int w = 0; w < WAYS; w++) age_d[cnt_q][w] = AW'(w);
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = cnt_q == IDX_W'(SETS - 1) ? IDLE : FLUSH;
        end else begin
            if (touch) age_d[idx] = age_new;
            if (we) begin
                valid_d[idx][sel] = 1'b1;
                dirty_d[idx][sel] = dirty_i;
            end
            if (flush_i) begin
                state_d = FLUSH;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            age_q   <= age_d;
        end
    end

    // Tag and data arrays carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[idx][sel]  <= tag;
            data_mem[idx][sel] <= wdata_i;
            id_mem[idx][sel]   <= I_D;
        end
    end

`ifdef CACHE_SRAM_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (!flushing && flush_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (!flushing && read_i) begin
            if (hit_any) hit_cnt_d = hit_cnt_q + 32'(hit_cnt_q != '1);
            else miss_cnt_d = miss_cnt_q + 32'(miss_cnt_q != '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_sram_assoc.sv
// tb_cache_sram_assoc: scoreboard bench for cache_sram_assoc against a recency-list reference model.
module tb_cache_sram_assoc;
    localparam int WAYS = 4, SETS = 32, TAG_W = 23, LINE_W = 128, IDX_W = 5;

    logic              clk = 0, rst_n = 0;
    logic [TAG_W+IDX_W-1:0] addr_i = '0;
    logic              I_D = 0, read_i = 0, write_i = 0, dirty_i = 0, flush_i = 0;
    logic [LINE_W-1:0] wdata_i = '0, rdata_o;
    logic              hit_o, victim_dirty_o, busy_o;
    logic [TAG_W-1:0]  victim_tag_o;
`ifdef CACHE_SRAM_STATS_EN
    logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

    cache_sram_assoc dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .I_D(I_D), .read_i(read_i),
        .write_i(write_i), .dirty_i(dirty_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .rdata_o(rdata_o), .hit_o(hit_o), .victim_dirty_o(victim_dirty_o),
        .victim_tag_o(victim_tag_o),
`ifdef CACHE_SRAM_STATS_EN
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              busy, hit, vd, chk;
        logic [TAG_W-1:0]  vtag;
        logic [LINE_W-1:0] rdata;
        longint            hc, mc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    // Reference model: line contents plus a recency list per set (most recent first).
    logic              m_v[SETS][WAYS], m_d[SETS][WAYS], m_id[SETS][WAYS];
    logic [TAG_W-1:0]  m_tag[SETS][WAYS];
    logic [LINE_W-1:0] m_data[SETS][WAYS];
    int                m_lru[SETS][WAYS];
    int                fl_left;
    longint            m_hits, m_miss;

    function automatic void reset_set(int s);
        for (int w = 0; w < WAYS; w++) begin
            m_v[s][w]   = 0;
            m_d[s][w]   = 0;
            m_lru[s][w] = w;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) reset_set(s);
        fl_left = 0;
        m_hits  = 0;
        m_miss  = 0;
    endfunction

    function automatic void touch(int s, int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_lru[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_lru[s][i] = m_lru[s][i-1];
        m_lru[s][0] = w;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic op(string name, bit rd, bit wr, bit fl, int t, int s, bit id, bit dty,
                      logic [LINE_W-1:0] data);
        exp_t e;
        int hw = -1, inv = -1, sel;
        bit busy;
        @(posedge clk); #1;
        read_i  = rd;
        write_i = wr;
        flush_i = fl;
        addr_i  = {TAG_W'(t), IDX_W'(s)};
        I_D     = id;
        dirty_i = dty;
        wdata_i = data;
        busy = fl_left > 0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (m_v[s][w] && m_tag[s][w] == TAG_W'(t) && m_id[s][w] == id) hw = w;
            if (!m_v[s][w]) inv = w;
        end
        sel = hw >= 0 ? hw : inv >= 0 ? inv : m_lru[s][WAYS-1];
        e.name  = name;
        e.busy  = busy;
        e.hit   = hw >= 0 && !busy;
        e.vd    = m_v[s][sel] && m_d[s][sel] && !busy;
        e.chk   = m_v[s][sel] && !busy;
        e.vtag  = m_tag[s][sel];
        e.rdata = m_data[s][sel];
        e.hc    = m_hits;
        e.mc    = m_miss;
        sb.push_back(e);
        if (busy) begin
            reset_set(SETS - fl_left);
            fl_left--;
        end else begin
            if (wr) begin
                m_v[s][sel]    = 1;
                m_d[s][sel]    = dty;
                m_id[s][sel]   = id;
                m_tag[s][sel]  = TAG_W'(t);
                m_data[s][sel] = data;
                touch(s, sel);
            end else if (rd && hw >= 0) touch(s, sel);
            if (fl) begin
                fl_left = SETS;
                m_hits  = 0;
                m_miss  = 0;
            end else if (rd) begin
                if (hw >= 0) m_hits = m_hits < 64'hFFFF_FFFF ? m_hits + 1 : m_hits;
                else m_miss = m_miss < 64'hFFFF_FFFF ? m_miss + 1 : m_miss;
            end
        end
    endtask

    task automatic rd_op(string name, int t, int s, bit id);
        op(name, 1, 0, 0, t, s, id, 0, '0);
    endtask

    task automatic wr_op(string name, int t, int s, bit id, bit dty, logic [LINE_W-1:0] data);
        op(name, 0, 1, 0, t, s, id, dty, data);
    endtask

    task automatic rst_pulse(string name);
        exp_t e;
        @(posedge clk); #1;
        rst_n   = 0;
        read_i  = 0;
        write_i = 0;
        flush_i = 0;
        model_reset();
        e.name = name;
        e.busy = 0;
        e.hit  = 0;
        e.vd   = 0;
        e.chk  = 0;
        e.vtag = '0;
        e.rdata = '0;
        e.hc   = 0;
        e.mc   = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (busy_o !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s busy_o got %0b want %0b", e.name, busy_o, e.busy);
                end
                if (hit_o !== e.hit) begin
                    miscompares++;
                    $display("FAIL %s hit_o got %0b want %0b", e.name, hit_o, e.hit);
                end
                if (victim_dirty_o !== e.vd) begin
                    miscompares++;
                    $display("FAIL %s victim_dirty_o got %0b want %0b", e.name, victim_dirty_o, e.vd);
                end
                if (e.chk && victim_tag_o !== e.vtag) begin
                    miscompares++;
                    $display("FAIL %s victim_tag_o got %0h want %0h", e.name, victim_tag_o, e.vtag);
                end
                if (e.chk && rdata_o !== e.rdata) begin
                    miscompares++;
                    $display("FAIL %s rdata_o got %0h want %0h", e.name, rdata_o, e.rdata);
                end
`ifdef CACHE_SRAM_STATS_EN
                if (64'(hit_cnt_o) != e.hc || 64'(miss_cnt_o) != e.mc) begin
                    miscompares++;
                    $display("FAIL %s stats got %0d/%0d want %0d/%0d", e.name, hit_cnt_o, miss_cnt_o,
                             e.hc, e.mc);
                end
`endif
            end
        end
    end

    initial begin
        logic [LINE_W-1:0] d;
        int sets_pick[4] = '{3, 5, 6, 9};
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        rd_op("reset_read", 0, 5, 0);

        for (int t = 1; t <= 4; t++) wr_op("fill_s5", t, 5, 0, 0, rnd_line());
        rd_op("read_tag1", 1, 5, 0);
        rd_op("miss_tag9_victim", 9, 5, 0);
        wr_op("write_tag9", 9, 5, 0, 0, rnd_line());
        rd_op("reread_tag9", 9, 5, 0);
        rd_op("tag2_gone", 2, 5, 0);

        d = rnd_line();
        wr_op("write_tag7_i", 7, 10, 1, 0, d);
        rd_op("tag7_d_miss", 7, 10, 0);
        rd_op("tag7_i_hit", 7, 10, 1);

        for (int t = 1; t <= 4; t++) wr_op("fill_s3_dirty", t, 3, 0, 1, rnd_line());
        rd_op("dirty_victim", 5, 3, 0);

        for (int s = 0; s < 8; s++) wr_op("prefill", s + 20, s, 0, 1, rnd_line());
        op("flush_start", 0, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < SETS; i++)
            op("write_in_flush", 1, 1, 0, 30, i % 8, 0, 1, rnd_line());
        rd_op("post_flush_idle", 0, 0, 0);
        for (int s = 0; s < 8; s++) rd_op("post_flush_miss", s + 20, s, 0);
        for (int t = 1; t <= 6; t++) wr_op("refill_age_order", t, 5, 0, t[0], rnd_line());
        for (int t = 1; t <= 6; t++) rd_op("refill_check", t, 5, 0);

        for (int t = 1; t <= 4; t++) wr_op("fill_before_rst", t, 12, 0, 1, rnd_line());
        op("flush_then_rst", 0, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) rd_op("flush_cycle", 1, 12, 0);
        rst_pulse("rst_in_flush");
        for (int t = 1; t <= 4; t++) rd_op("after_rst_miss", t, 12, 0);
        rd_op("after_rst_miss5", 9, 5, 0);

        wr_op("stats_fill", 1, 4, 0, 0, rnd_line());
        for (int i = 0; i < 3; i++) rd_op("stats_hit", 1, 4, 0);
        for (int i = 0; i < 2; i++) rd_op("stats_miss", 2, 4, 0);
        rd_op("stats_check", 3, 4, 1);

        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            op("random", r >= 30, r < 45, r == 99, $urandom_range(1, 6), sets_pick[$urandom_range(0, 3)],
               $urandom_range(0, 1), $urandom_range(0, 1), rnd_line());
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
